// File: rtl/ss_map_pkg.sv
// Shared types and constants for the world-map sequencer.
// Holds the FSM encoding and map index arithmetic.
package ss_map_pkg;

  localparam int MAX_MAPS  = 16;
  localparam int MAP_IDX_W = 4;

  typedef logic [MAP_IDX_W-1:0] map_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_COMMIT,
    ST_HOLD
  } seq_state_t;

  // Neighbour map index; clamps at the ends unless wrap is set.
  function automatic map_idx_t step_idx(
    input map_idx_t    cur,
    input logic        fwd,
    input int unsigned num_maps,
    input logic        wrap
  );
    int unsigned last;
    int unsigned c;
    int unsigned n;
    last = num_maps - 32'd1;
    c    = 32'(cur);
    if (fwd) begin
      if (c == last) n = wrap ? 32'd0 : last;
      else           n = c + 32'd1;
    end else begin
      if (c == 32'd0) n = wrap ? last : 32'd0;
      else            n = c - 32'd1;
    end
    return map_idx_t'(n);
  endfunction

endpackage

// File: rtl/ss_map_sequencer_if.sv
// Tile-data bus between the map BRAMs and the sequencer.
// The BRAM side drives both ports; the sequencer returns the selection.
interface ss_map_sequencer_if #(
  parameter int NUM_MAPS = 4,
  parameter int DATA_W   = 2
);

  logic [NUM_MAPS*DATA_W-1:0] map_data_a;
  logic [NUM_MAPS*DATA_W-1:0] map_pixel_b;
  logic [DATA_W-1:0]          worldmap_data;
  logic [DATA_W-1:0]          world_pixel;

  modport master (
    output map_data_a,
    output map_pixel_b,
    input  worldmap_data,
    input  world_pixel
  );

  modport slave (
    input  map_data_a,
    input  map_pixel_b,
    output worldmap_data,
    output world_pixel
  );

endinterface

// File: rtl/ss_locx_edge_det.sv
// Registers the player X location and flags fresh arrivals
// at the forward and backward screen edges.
module ss_locx_edge_det #(
  parameter int                LOCX_W  = 8,
  parameter logic [LOCX_W-1:0] EDGE_HI = LOCX_W'(8'h7C),
  parameter logic [LOCX_W-1:0] EDGE_LO = LOCX_W'(8'h00)
) (
  input  logic              clk_75,
  input  logic              reset,
  input  logic [LOCX_W-1:0] locx,
  output logic              fwd_ev,
  output logic              back_ev
);

  logic [LOCX_W-1:0] locx_q;
  logic [LOCX_W-1:0] locx_d;
  logic              moved;

  always_comb begin
    locx_d = locx;
  end

  always_ff @(posedge clk_75 or negedge reset) begin
    if (!reset) locx_q <= '0;
    else        locx_q <= locx_d;
  end

  // Only a change onto an edge counts, so parking there is silent.
  assign moved   = (locx != locx_q);
  assign fwd_ev  = moved && (locx == EDGE_HI);
  assign back_ev = moved && (locx == EDGE_LO);

endmodule

// File: rtl/ss_map_sequencer.sv
// World-map sequencer: walks between maps when the player crosses
// a screen edge, committing the switch only during vertical blanking.
module ss_map_sequencer
  import ss_map_pkg::*;
#(
  parameter int                NUM_MAPS = 4,
  parameter int                DATA_W   = 2,
  parameter int                LOCX_W   = 8,
  parameter logic [LOCX_W-1:0] EDGE_HI  = LOCX_W'(8'h7C),
  parameter logic [LOCX_W-1:0] EDGE_LO  = LOCX_W'(8'h00),
  parameter bit                WRAP     = 1'b0
) (
  input  logic              clk_75,
  input  logic              reset,
  input  logic [LOCX_W-1:0] locx,
  input  logic              vblank,
  input  logic              seq_en,
  ss_map_sequencer_if.slave bus,
  output logic [3:0]        current_map,
  output logic              map_changed,
  output logic              pending
);

  if (NUM_MAPS < 2 || NUM_MAPS > MAX_MAPS) begin : g_bad_maps
    $error("ss_map_sequencer: NUM_MAPS must be 2..16");
  end

  seq_state_t state_q, state_d;
  map_idx_t   cur_q, cur_d;
  map_idx_t   target_q, target_d;
  map_idx_t   sel_q, sel_d;
  logic       dir_q, dir_d;
  logic       fwd_ev, back_ev;
  logic       cancel;
  logic       off_edge;
  map_idx_t   fwd_t, back_t;
  logic       chg;
  logic       pend;

  ss_locx_edge_det #(
    .LOCX_W  (LOCX_W),
    .EDGE_HI (EDGE_HI),
    .EDGE_LO (EDGE_LO)
  ) u_edge (
    .clk_75  (clk_75),
    .reset   (reset),
    .locx    (locx),
    .fwd_ev  (fwd_ev),
    .back_ev (back_ev)
  );

  assign fwd_t    = step_idx(cur_q, 1'b1,
                             NUM_MAPS, WRAP);
  assign back_t   = step_idx(cur_q, 1'b0,
                             NUM_MAPS, WRAP);
  assign cancel   = dir_q ? back_ev : fwd_ev;
  assign off_edge = (locx != EDGE_HI) &&
                    (locx != EDGE_LO);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    target_d = target_q;
    dir_d    = dir_q;
    chg      = 1'b0;
    pend     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (seq_en && fwd_ev &&
            fwd_t != cur_q) begin
          target_d = fwd_t;
          dir_d    = 1'b1;
          state_d  = ST_PEND;
        end else if (seq_en && back_ev &&
                     back_t != cur_q) begin
          target_d = back_t;
          dir_d    = 1'b0;
          state_d  = ST_PEND;
        end
      end
      ST_PEND: begin
        pend = 1'b1;
        if (!seq_en || cancel) begin
          target_d = '0;
          state_d  = ST_IDLE;
        end else if (vblank) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        chg     = 1'b1;
        cur_d   = target_q;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (off_edge) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select trails the committed index to line up with BRAM latency.
  assign sel_d = cur_q;

  always_ff @(posedge clk_75 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      sel_q    <= sel_d;
    end
  end

  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] wp;

  always_comb begin
    wd = '0;
    wp = '0;
    for (int i = 0; i < NUM_MAPS; i++) begin
      if (sel_q == map_idx_t'(i)) begin
        wd = bus.map_data_a[i*DATA_W +: DATA_W];
        wp = bus.map_pixel_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.worldmap_data = wd;
  assign bus.world_pixel   = wp;
  assign current_map       = cur_q;
  assign map_changed       = chg;
  assign pending           = pend;

endmodule

// File: tb/tb_ss_map_sequencer.sv
// Bench for ss_map_sequencer: a saturating and a wrapping instance
// share stimulus and are compared with a behavioural model.
module tb_ss_map_sequencer;

  logic       clk_75 = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] locx   = 8'h00;
  logic       vblank = 1'b0;
  logic       seq_en = 1'b0;

  logic [3:0] cur0, cur1;
  logic       chg0, chg1;
  logic       pend0, pend1;

  int checks   = 0;
  int failures = 0;

  always #5 clk_75 = ~clk_75;

  ss_map_sequencer_if #(.NUM_MAPS(4), .DATA_W(2)) if0 ();
  ss_map_sequencer_if #(.NUM_MAPS(4), .DATA_W(2)) if1 ();

  // Map i reads back i on port A and 3-i on port B.
  assign if0.map_data_a  = {2'd3, 2'd2, 2'd1, 2'd0};
  assign if0.map_pixel_b = {2'd0, 2'd1, 2'd2, 2'd3};
  assign if1.map_data_a  = {2'd3, 2'd2, 2'd1, 2'd0};
  assign if1.map_pixel_b = {2'd0, 2'd1, 2'd2, 2'd3};

  ss_map_sequencer #(.WRAP(1'b0)) u0 (
    .clk_75      (clk_75),
    .reset       (reset),
    .locx        (locx),
    .vblank      (vblank),
    .seq_en      (seq_en),
    .bus         (if0),
    .current_map (cur0),
    .map_changed (chg0),
    .pending     (pend0)
  );

  ss_map_sequencer #(.WRAP(1'b1)) u1 (
    .clk_75      (clk_75),
    .reset       (reset),
    .locx        (locx),
    .vblank      (vblank),
    .seq_en      (seq_en),
    .bus         (if1),
    .current_map (cur1),
    .map_changed (chg1),
    .pending     (pend1)
  );

  logic [9:0] obs [2];
  assign obs[0] = {cur0, chg0, pend0,
                   if0.worldmap_data, if0.world_pixel};
  assign obs[1] = {cur1, chg1, pend1,
                   if1.worldmap_data, if1.world_pixel};

  // Reference model: per-instance view of the player's map progress.
  int m_cur  [2];
  int m_sel  [2];
  int m_tgt  [2];
  int m_prev [2];
  bit m_wait [2];
  bit m_due  [2];
  bit m_park [2];
  bit m_dir  [2];

  function automatic int neighbour(int cur, bit fwd, int w);
    if (w == 1) return fwd ? (cur + 1) % 4 : (cur + 3) % 4;
    if (fwd) return (cur < 3) ? cur + 1 : 3;
    return (cur > 0) ? cur - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_cur[w]  = 0;
      m_sel[w]  = 0;
      m_tgt[w]  = 0;
      m_prev[w] = 0;
      m_wait[w] = 0;
      m_due[w]  = 0;
      m_park[w] = 0;
      m_dir[w]  = 0;
    end
  endtask

  task automatic model_update();
    bit fwd;
    bit back;
    int t;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int w = 0; w < 2; w++) begin
      fwd  = (int'(locx) != m_prev[w]) && locx == 8'h7C;
      back = (int'(locx) != m_prev[w]) && locx == 8'h00;
      m_sel[w] = m_cur[w];
      if (m_due[w]) begin
        m_cur[w]  = m_tgt[w];
        m_due[w]  = 0;
        m_park[w] = 1;
      end else if (m_park[w]) begin
        if (locx != 8'h7C && locx != 8'h00) m_park[w] = 0;
      end else if (m_wait[w]) begin
        if (!seq_en || (m_dir[w] ? back : fwd))
          m_wait[w] = 0;
        else if (vblank) begin
          m_wait[w] = 0;
          m_due[w]  = 1;
        end
      end else if (seq_en && (fwd || back)) begin
        t = neighbour(m_cur[w], fwd, w);
        if (t != m_cur[w]) begin
          m_wait[w] = 1;
          m_tgt[w]  = t;
          m_dir[w]  = fwd;
        end
      end
      m_prev[w] = int'(locx);
    end
  endtask

  function automatic logic [9:0] expv(int w);
    return {4'(m_cur[w]), m_due[w], m_wait[w],
            2'(m_sel[w]), 2'(3 - m_sel[w])};
  endfunction

  task automatic step(input logic [7:0] l,
                      input bit v, input bit e);
    locx   = l;
    vblank = v;
    seq_en = e;
    @(posedge clk_75);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) step(8'h10, 1'b1, 1'b1);
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs[w] !== 10'b0000_0_0_00_11) begin
        failures++;
        $display("FAIL reset dut%0d got=%h exp=%h",
                 w, obs[w], 10'b0000_0_0_00_11);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_advance();
    for (int c = 0; c < 3; c++) step(8'h10, 1'b0, 1'b1);
    for (int c = 0; c < 51; c++) begin
      step(8'h7C, 1'b0, 1'b1);
      checks++;
      if (pend0 !== 1'b1) begin
        failures++;
        $display("FAIL adv_pending cyc=%0d got=%b exp=1",
                 c, pend0);
      end
    end
    step(8'h7C, 1'b1, 1'b1);
    checks++;
    if (chg0 !== 1'b1) begin
      failures++;
      $display("FAIL adv_pulse got=%b exp=1", chg0);
    end
    step(8'h7C, 1'b0, 1'b1);
    checks++;
    if (cur0 !== 4'd1 || chg0 !== 1'b0) begin
      failures++;
      $display("FAIL adv_map got=%0d/%b exp=1/0",
               cur0, chg0);
    end
    // Port data follows one cycle after the committed index.
    checks++;
    if (if0.worldmap_data !== 2'd0) begin
      failures++;
      $display("FAIL adv_mux_lag got=%0d exp=0",
               if0.worldmap_data);
    end
    step(8'h7C, 1'b0, 1'b1);
    checks++;
    if (if0.worldmap_data !== 2'd1 ||
        if0.world_pixel !== 2'd2) begin
      failures++;
      $display("FAIL adv_mux got=%0d/%0d exp=1/2",
               if0.worldmap_data, if0.world_pixel);
    end
  endtask

  task automatic test_cancel();
    for (int c = 0; c < 2; c++) step(8'h40, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) step(8'h7C, 1'b0, 1'b1);
    checks++;
    if (pend0 !== 1'b1) begin
      failures++;
      $display("FAIL cancel_arm got=%b exp=1", pend0);
    end
    step(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step(8'h00, 1'b1, 1'b1);
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (obs[w] !== expv(w)) begin
          failures++;
          $display("FAIL cancel dut%0d got=%h exp=%h",
                   w, obs[w], expv(w));
        end
      end
    end
    checks++;
    if (cur0 !== 4'd1 || pend0 !== 1'b0) begin
      failures++;
      $display("FAIL cancel_map got=%0d/%b exp=1/0",
               cur0, pend0);
    end
  endtask

  task automatic test_hold();
    int pulses;
    for (int r = 0; r < 2; r++) begin
      pulses = 0;
      for (int c = 0; c < 2; c++) step(8'h40, 1'b0, 1'b1);
      step(8'h7C, 1'b0, 1'b1);
      for (int c = 0; c < 200; c++) begin
        step(8'h7C, 1'b1, 1'b1);
        if (chg0 === 1'b1) pulses++;
        for (int w = 0; w < 2; w++) begin
          checks++;
          if (obs[w] !== expv(w)) begin
            failures++;
            $display("FAIL hold r%0d dut%0d got=%h exp=%h",
                     r, w, obs[w], expv(w));
          end
        end
      end
      checks++;
      if (pulses != 1 || cur0 !== 4'(2 + r)) begin
        failures++;
        $display("FAIL hold_once r%0d got=%0d/%0d exp=1/%0d",
                 r, pulses, cur0, 2 + r);
      end
    end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 2; c++) step(8'h40, 1'b0, 1'b1);
    step(8'h7C, 1'b1, 1'b1);
    checks++;
    if (pend0 !== 1'b0 || pend1 !== 1'b1) begin
      failures++;
      $display("FAIL sat_pend got=%b/%b exp=0/1",
               pend0, pend1);
    end
    step(8'h7C, 1'b1, 1'b1);
    checks++;
    if (chg1 !== 1'b1 || chg0 !== 1'b0) begin
      failures++;
      $display("FAIL sat_pulse got=%b/%b exp=0/1",
               chg0, chg1);
    end
    step(8'h7C, 1'b1, 1'b1);
    checks++;
    if (cur0 !== 4'd3 || cur1 !== 4'd0) begin
      failures++;
      $display("FAIL sat_map got=%0d/%0d exp=3/0",
               cur0, cur1);
    end
  endtask

  task automatic test_random();
    logic [7:0] l;
    int         r;
    l = 8'h40;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 7);
      if (r < 2)       l = 8'h7C;
      else if (r == 2) l = 8'h00;
      else if (r > 4)  l = 8'($urandom);
      step(l, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) != 0);
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (obs[w] !== expv(w)) begin
          failures++;
          $display("FAIL rand c%0d dut%0d got=%h exp=%h",
                   c, w, obs[w], expv(w));
        end
      end
    end
  endtask

  task automatic test_reset_pending();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 3; c++) step(8'h40, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    checks++;
    if (pend0 !== 1'b1 || pend1 !== 1'b1) begin
      failures++;
      $display("FAIL rp_arm got=%b/%b exp=1/1",
               pend0, pend1);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs[w] !== 10'b0000_0_0_00_11) begin
        failures++;
        $display("FAIL rp_async dut%0d got=%h exp=%h",
                 w, obs[w], 10'b0000_0_0_00_11);
      end
    end
    for (int c = 0; c < 2; c++) step(8'h00, 1'b1, 1'b1);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(8'h00, 1'b1, 1'b1);
      if (chg0 === 1'b1 || chg1 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || cur0 !== 4'd0 || cur1 !== 4'd0) begin
      failures++;
      $display("FAIL rp_quiet got=%0d/%0d/%0d exp=0/0/0",
               pulses, cur0, cur1);
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_cancel();
    test_hold();
    test_saturate();
    test_random();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ss_map_sequencer.md
SS_MAP_SEQUENCER -- requirements
Module: ss_map_sequencer

Interface
REQ-001 Parameter NUM_MAPS, default 4: number of world maps selectable, 2..16.
REQ-002 Parameter DATA_W, default 2: tile data width per map port.
REQ-003 Parameter LOCX_W, default 8: player X-location width.
REQ-004 Parameter EDGE_HI, default 8'h7C: LocX value that advances to the next map.
REQ-005 Parameter EDGE_LO, default 8'h00: LocX value that returns to the previous map.
REQ-006 Parameter WRAP, default 0: 1 = map index wraps at ends; 0 = saturates.
REQ-007 clk_75  in  1  pixel/system clock; all logic rising-edge.
REQ-008 reset  in  1  reset, asynchronous, active-low.
REQ-009 locx  in  LOCX_W  player X location, synchronous to clk_75.
REQ-010 vblank  in  1  high during vertical blanking; map commits allowed only then.
REQ-011 seq_en  in  1  enables edge-triggered map transitions.
REQ-012 map_data_a  in  NUM_MAPS*DATA_W  port-A BRAM outputs (game logic), map i at bits [i*DATA_W +: DATA_W].
REQ-013 map_pixel_b  in  NUM_MAPS*DATA_W  port-B BRAM outputs (video), same packing.
REQ-014 worldmap_data  out  DATA_W  selected port-A data.
REQ-015 world_pixel  out  DATA_W  selected port-B data.
REQ-016 current_map  out  4  committed map index.
REQ-017 map_changed  out  1  one-cycle pulse on commit.
REQ-018 pending  out  1  high while a transition waits for vblank.

Function
REQ-019 locx SHALL be registered once (locx_q); an edge event SHALL be locx != locx_q AND locx equals EDGE_HI (fwd) or EDGE_LO (back); a static locx at an edge SHALL NOT retrigger.
REQ-020 FSM states: IDLE, PEND, COMMIT, HOLD.
REQ-021 IDLE: on edge event with seq_en=1, latch target = next/prev index, go PEND; if target equals current_map (saturated end, WRAP=0) stay IDLE.
REQ-022 PEND: pending=1; when vblank=1 go COMMIT; a new opposite-direction edge event in PEND SHALL cancel (return IDLE, target discarded); same-direction event ignored.
REQ-023 COMMIT: current_map <= target, map_changed=1 for exactly this cycle, go HOLD.
REQ-024 HOLD: stay until locx differs from both EDGE_HI and EDGE_LO, then IDLE; edge events ignored in HOLD.
REQ-025 Index arithmetic: fwd = current_map+1, back = current_map-1, in NUM_MAPS range; WRAP=1 wraps NUM_MAPS-1<->0; WRAP=0 clamps.
REQ-026 seq_en=0 SHALL force PEND back to IDLE next cycle; a COMMIT in progress completes.
REQ-027 Output mux select SHALL be current_map delayed one clk_75 cycle (sel_q), matching 1-cycle BRAM read latency; worldmap_data and world_pixel SHALL be combinational from sel_q and the input buses.
REQ-028 Edge event and vblank in same IDLE cycle: enter PEND; commit no earlier than next cycle (2-cycle min latency event->map_changed).

Reset
REQ-029 On reset low: state=IDLE, current_map=0, sel_q=0, target=0, locx_q=0, map_changed=0, pending=0; effect immediate (asynchronous), release synchronous to clk_75.
REQ-030 Reset mid-PEND or mid-COMMIT SHALL discard the transition with no map_changed pulse.

Structure
REQ-031 Package ss_map_pkg SHALL hold the FSM state enum, MAX_MAPS=16 and map index width constant.
REQ-032 Sub-module ss_locx_edge_det SHALL implement REQ-019 (locx_q register, fwd/back event outputs).
REQ-033 BRAMs SHALL be instantiated outside this block; parameter check: NUM_MAPS<2 or >16 SHALL fail elaboration.

Verification
REQ-034 Reset, locx 0x10->0x7C, vblank low 50 cycles then high -> pending=1 throughout, map_changed 1 cycle after vblank rises, current_map=1.
REQ-035 WRAP=0, current_map=3 (NUM_MAPS=4), locx hits 0x7C with vblank=1 -> no PEND, current_map stays 3; WRAP=1 same stimulus -> current_map=0.
REQ-036 locx held at 0x7C 200 cycles after commit -> exactly one map_changed; locx to 0x40 then 0x7C -> second advance.
REQ-037 Fwd event, then locx to 0x00 before vblank -> PEND cancelled, no map_changed, current_map unchanged.
REQ-038 Distinct constant data per map (map i = i) -> world_pixel/worldmap_data change exactly 1 cycle after current_map changes.
REQ-039 reset asserted while pending=1 -> outputs at reset values same cycle, no map_changed after release.
